// File: rtl/foo_ab_pkg.sv
// Shared types for the foo {a,b} stimulus driver.
package foo_ab_pkg;

  // Width of the hold field carried in each buffered word.
  localparam int AB_HOLD_W = 8;

  typedef struct packed {
    logic                 a;
    logic                 b;
    logic [AB_HOLD_W-1:0] hold;
  } ab_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } drv_state_e;

endpackage

// File: rtl/foo_ab_fifo.sv
// Synchronous FIFO of ab_entry_t words with registered occupancy.
// The caller gates push with !full and pop with !empty.
module foo_ab_fifo
  import foo_ab_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  ab_entry_t        din_i,
  input  logic             pop_i,
  output ab_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  ab_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == DEPTH_L);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Occupancy next-state: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/foo_ab_driver.sv
// Buffers {a,b,hold} words and replays each on registered a/b for hold+1 cycles.
//   state | meaning
//   IDLE  | nothing being driven; a/b park at the last driven value
//   DRIVE | a word is on a/b; hold counter counts its remaining extra cycles
// HOLD_W must equal the hold field width of ab_entry_t.
module foo_ab_driver
  import foo_ab_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int HOLD_W = AB_HOLD_W,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_a,
  input  logic              in_b,
  input  logic [HOLD_W-1:0] in_hold,
  output logic              a,
  output logic              b,
  output logic              out_valid,
  output logic              busy,
  output logic [LVL_W-1:0]  level
);

  drv_state_e        state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              a_q, a_d, b_q, b_d;
  logic              valid_q, valid_d;
  logic              push, pop, full, empty;
  ab_entry_t         wr_entry, head;

  assign wr_entry = '{a: in_a, b: in_b, hold: in_hold};
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;

  foo_ab_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (wr_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // Next-state: load a word from IDLE, or back-to-back when the current one expires.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          a_d     = head.a;
          b_d     = head.b;
          cnt_d   = head.hold;
          valid_d = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!empty) begin
          pop   = 1'b1;
          a_d   = head.a;
          b_d   = head.b;
          cnt_d = head.hold;
        end else begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, hold counter and output registers; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign out_valid = valid_q;
  assign busy      = (level != '0) || valid_q;

endmodule

// File: tb/tb_foo_ab_driver.sv
// Randomised bench for foo_ab_driver against a queue-based replay model.
module tb_foo_ab_driver;

  localparam int DEPTH  = 4;
  localparam int HOLD_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_a = 1'b0;
  logic              in_b = 1'b0;
  logic [HOLD_W-1:0] in_hold = '0;
  logic              in_ready;
  logic              a, b, out_valid, busy;
  logic [2:0]        level;

  foo_ab_driver #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_hold   (in_hold),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .busy      (busy),
    .level     (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Model: words waiting in the buffer, plus how many display cycles the
  // current word still owns (0 means nothing on the outputs).
  bit [9:0] q_m[$];
  int       rem_m = 0;
  bit       a_m = 0, b_m = 0, v_m = 0;

  task automatic cycle(input bit r, input bit v, input bit wa, input bit wb, input bit [7:0] h);
    bit       rdy;
    bit [9:0] w;
    rst = r; in_valid = v; in_a = wa; in_b = wb; in_hold = h;
    #1;
    rdy = !r && (q_m.size() < DEPTH);
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    if (r) begin
      q_m.delete();
      rem_m = 0; a_m = 0; b_m = 0; v_m = 0;
    end else begin
      if (rem_m > 0) rem_m--;
      if (rem_m == 0) begin
        if (q_m.size() > 0) begin
          w = q_m.pop_front();
          a_m = w[9]; b_m = w[8]; rem_m = int'(w[7:0]) + 1; v_m = 1;
        end else begin
          v_m = 0;
        end
      end
      if (v && rdy) q_m.push_back({wa, wb, h});
    end
    @(negedge clk);
    check("a",         {31'd0, a},         {31'd0, a_m});
    check("b",         {31'd0, b},         {31'd0, b_m});
    check("out_valid", {31'd0, out_valid}, {31'd0, v_m});
    check("level",     {29'd0, level},     q_m.size());
    check("busy",      {31'd0, busy},      {31'd0, (q_m.size() != 0) || v_m});
    check("level_max", {31'd0, (level <= 3'(DEPTH))}, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 8'd0);
  endtask

  initial begin
    @(negedge clk);
    // Reset held three cycles, then release.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 8'd0);
    idle(2);

    // Single word {1,0,hold=2}.
    cycle(0, 1, 1, 0, 8'd2);
    idle(5);

    // Back-to-back words with mixed holds.
    cycle(0, 1, 1, 1, 8'd0);
    cycle(0, 1, 0, 1, 8'd1);
    cycle(0, 1, 1, 0, 8'd0);
    idle(5);

    // Long-held head stalls the drain; keep offering words to hit full.
    cycle(0, 1, 0, 1, 8'd255);
    for (int i = 0; i < 270; i++)
      cycle(0, 1, 1'($urandom), 1'($urandom), 8'd0);
    idle(8);

    // Reset in the middle of a drive with words queued.
    cycle(0, 1, 1, 1, 8'd3);
    cycle(0, 1, 0, 1, 8'd3);
    cycle(0, 1, 1, 0, 8'd3);
    idle(1);
    cycle(1, 0, 0, 0, 8'd0);
    idle(8);

    // Ten hold-0 words back to back exercise pointer wrap.
    for (int i = 0; i < 10; i++)
      cycle(0, 1, 1'($urandom), 1'($urandom), 8'd0);
    idle(15);

    // Random traffic with occasional reset.
    for (int i = 0; i < 500; i++)
      cycle(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom_range(0, 3)));
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
